// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-master arbiter for the data RAM read/write port
//
// Purpose: shares RAM port A between M0 (CPU load/store, priority) and M1
// (loader/DMA, guaranteed service after STARVE_LIMIT denied cycles).
// At most one request is granted per cycle. Read data comes back one cycle
// after the grant and is steered to the master that issued the read.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mN_req/we/addr/wdata      master N request (we all-zero = read)
//   mN_gnt                    master N request accepted this cycle (combinational)
//   mN_rvalid/rdata           master N read return, one cycle after a read grant
//   ram_we/addr/wdata         drive to RAM port A
//   ram_rdata                 RAM port A read data, valid one cycle after address
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_BYTES   = DATA_WIDTH / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [DATA_BYTES-1:0] m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic [DATA_BYTES-1:0] m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [DATA_BYTES-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [7:0] starve_cnt;
  logic       force_m1;
  logic       rd_valid;   // a read was granted last cycle
  logic       rd_owner;   // 0 = M0, 1 = M1; only meaningful with rd_valid
  logic       rd_grant;

  // M1 overrides M0 once it has waited STARVE_LIMIT consecutive cycles.
  assign force_m1 = m1_req && (starve_cnt >= 8'(STARVE_LIMIT));
  assign m1_gnt   = !rst && m1_req && (force_m1 || !m0_req);
  assign m0_gnt   = !rst && m0_req && !m1_gnt;

  // Address/data default to M0's fields when idle; only the write enables
  // need to be quiet, since an idle read of the RAM is harmless.
  assign ram_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign ram_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign ram_we    = m1_gnt ? m1_we : (m0_gnt ? m0_we : '0);

  assign rd_grant = (m0_gnt && (m0_we == '0)) || (m1_gnt && (m1_we == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'd0;
      rd_valid   <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_valid <= rd_grant;
      rd_owner <= m1_gnt;
      if (m1_gnt || !m1_req) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != 8'hFF) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // Gating with rst drops a read that was granted in the cycle just before
  // reset rose, so no stale return escapes while reset is held.
  assign m0_rvalid = rd_valid && !rd_owner && !rst;
  assign m1_rvalid = rd_valid &&  rd_owner && !rst;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int DB = 4;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req;
  logic [DB-1:0] m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [DB-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM port A: byte-enable write, registered read returning pre-write data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < DB; b++)
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word-array memory plus a plain integer wait counter.
  typedef struct { int m; logic [DW-1:0] data; int cyc; } rd_t;
  rd_t q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int wait_cnt = 0;

  task automatic preload(input int a, input logic [DW-1:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  always @(negedge clk) begin
    logic e0, e1;
    logic [DB-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    if (rst) begin
      e0 = 1'b0;
      e1 = 1'b0;
    end else begin
      e1 = m1_req && (wait_cnt >= LIMIT || !m0_req);
      e0 = m0_req && !e1;
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    we = e1 ? m1_we : (e0 ? m0_we : '0);
    a  = e1 ? m1_addr : m0_addr;
    wd = e1 ? m1_wdata : m0_wdata;
    chk("ram_we", 32'(ram_we), 32'(we));
    if (e0 || e1) begin
      chk("ram_addr", 32'(ram_addr), 32'(a));
      if (we != '0) begin
        chk("ram_wdata", ram_wdata, wd);
        for (int b = 0; b < DB; b++)
          if (we[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        q.push_back('{m: (e1 ? 1 : 0), data: ref_mem[a], cyc: cyc});
      end
    end
    if (rst || e1 || !m1_req) wait_cnt = 0;
    else if (wait_cnt < 255) wait_cnt++;
  end

  // Monitor: every read return must match the oldest outstanding read.
  always @(negedge clk) begin
    rd_t e;
    if (rst) begin
      chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
      chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
    end else if (q.size() > 0 && q[0].cyc == cyc - 1) begin
      e = q.pop_front();
      chk("rv_owner", {30'd0, m1_rvalid, m0_rvalid}, (e.m == 1) ? 32'd2 : 32'd1);
      chk("rdata", (e.m == 1) ? m1_rdata : m0_rdata, e.data);
    end else begin
      chk("rv_idle", {30'd0, m1_rvalid, m0_rvalid}, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = '0;
    m1_req = 0; m1_we = '0;
  endtask

  initial begin
    logic g0, g1;
    rst = 1;
    m0_req = 1; m0_we = 4'hF; m0_addr = 9'h1F0; m0_wdata = 32'h5555_5555;
    m1_req = 1; m1_we = 4'hF; m1_addr = 9'h1F1; m1_wdata = 32'hAAAA_AAAA;
    for (int i = 0; i < (1 << AW); i++) preload(i, $urandom);
    preload(9'h10, 32'hDEADBEEF);
    preload(9'h20, 32'h11223344);
    preload(9'h01, 32'hA0A0_0001);
    preload(9'h02, 32'hB0B0_0002);

    // Reset held 3 cycles with both masters writing.
    repeat (3) tick();
    rst = 0;
    idle_all();
    @(negedge clk);
    chk("rst_starve_cnt", 32'(dut.starve_cnt), 0);

    // Single read.
    tick();
    m0_req = 1; m0_we = '0; m0_addr = 9'h10;
    @(negedge clk);
    chk("sr_gnt", 32'(m0_gnt), 1);
    tick();
    idle_all();
    @(negedge clk);
    chk("sr_rvalid", 32'(m0_rvalid), 1);
    chk("sr_rdata", m0_rdata, 32'hDEADBEEF);
    chk("sr_m1_rvalid", 32'(m1_rvalid), 0);
    tick();
    @(negedge clk);
    chk("sr_rvalid_once", 32'(m0_rvalid), 0);

    // Byte write then read-back.
    tick();
    m1_req = 1; m1_we = 4'b0010; m1_addr = 9'h20; m1_wdata = 32'h0000AB00;
    @(negedge clk);
    chk("bw_gnt", 32'(m1_gnt), 1);
    tick();
    m1_we = '0;
    @(negedge clk);
    chk("bw_no_rvalid", 32'(m1_rvalid), 0);
    tick();
    idle_all();
    @(negedge clk);
    chk("bw_rvalid", 32'(m1_rvalid), 1);
    chk("bw_rdata", m1_rdata, 32'h1122AB44);

    // Starvation: M1 forced through every fifth cycle.
    tick();
    m0_req = 1; m0_we = '0; m0_addr = 9'h03;
    m1_req = 1; m1_we = '0; m1_addr = 9'h04;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk($sformatf("starve_m1_T%0d", t), 32'(m1_gnt), (t == 4 || t == 9) ? 32'd1 : 32'd0);
      chk($sformatf("starve_m0_T%0d", t), 32'(m0_gnt), (t == 4 || t == 9) ? 32'd0 : 32'd1);
      tick();
    end
    idle_all();
    tick();

    // Alternating reads.
    m0_req = 1; m0_we = '0; m0_addr = 9'h01;
    @(negedge clk);
    chk("alt_m0_gnt", 32'(m0_gnt), 1);
    tick();
    m0_req = 0;
    m1_req = 1; m1_we = '0; m1_addr = 9'h02;
    @(negedge clk);
    chk("alt_m0_rvalid", 32'(m0_rvalid), 1);
    chk("alt_m0_rdata", m0_rdata, 32'hA0A0_0001);
    chk("alt_m1_rvalid_early", 32'(m1_rvalid), 0);
    chk("alt_m1_gnt", 32'(m1_gnt), 1);
    tick();
    idle_all();
    @(negedge clk);
    chk("alt_m1_rvalid", 32'(m1_rvalid), 1);
    chk("alt_m1_rdata", m1_rdata, 32'hB0B0_0002);
    chk("alt_m0_rvalid_late", 32'(m0_rvalid), 0);

    // Reset in the cycle after a read grant.
    tick();
    m0_req = 1; m0_we = '0; m0_addr = 9'h10;
    @(negedge clk);
    chk("rmr_gnt", 32'(m0_gnt), 1);
    tick();
    idle_all();
    rst = 1;
    @(negedge clk);
    chk("rmr_rvalid_drop", 32'(m0_rvalid), 0);
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("rmr_no_stale_m0", 32'(m0_rvalid), 0);
    chk("rmr_no_stale_m1", 32'(m1_rvalid), 0);
    tick();
    m0_req = 1; m0_we = '0; m0_addr = 9'h10;
    @(negedge clk);
    tick();
    idle_all();
    @(negedge clk);
    chk("rmr_resume_rvalid", 32'(m0_rvalid), 1);
    chk("rmr_resume_rdata", m0_rdata, 32'hDEADBEEF);

    // Random traffic; masters hold their request until granted.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (!m0_req || g0) begin
        m0_req   = ($urandom_range(0, 99) < 70);
        m0_we    = $urandom_range(0, 1) ? 4'(0) : 4'($urandom_range(1, 15));
        m0_addr  = 9'($urandom_range(0, 15));
        m0_wdata = $urandom;
      end
      if (!m1_req || g1) begin
        m1_req   = ($urandom_range(0, 99) < 45);
        m1_we    = $urandom_range(0, 1) ? 4'(0) : 4'($urandom_range(1, 15));
        m1_addr  = 9'($urandom_range(0, 15));
        m1_wdata = $urandom;
      end
    end
    rst = 0;
    idle_all();
    repeat (3) tick();
    @(negedge clk);
    chk("sb_drain", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
